// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: shared state encoding, port indices and refresh counter sizing.
package sdram_arbiter_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_REF_ISSUE,
    S_REF_WAIT,
    S_RESPOND
  } state_t;
  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATA  = 1'b1;
  function automatic int refresh_cnt_w(input int cycles);
    return $clog2(cycles);
  endfunction
endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: port-side requests and controller-side command bus of the arbiter.
interface sdram_arbiter_if #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 16
);
  logic                  req0, req1, we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  ack0, ack1;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  mem_start, mem_refresh, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
  logic                  mem_done;
  logic                  refresh_overrun;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_done,
    output ack0, ack1, rdata, mem_start, mem_refresh, mem_we, mem_addr, mem_wdata, refresh_overrun
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_done,
    input  ack0, ack1, rdata, mem_start, mem_refresh, mem_we, mem_addr, mem_wdata, refresh_overrun
  );
endinterface

// File: rtl/sdram_arbiter_refresh_timer.sv
// sdram_refresh_timer: free-running refresh interval counter with pending and sticky overrun flags.
module sdram_refresh_timer
  import sdram_arbiter_pkg::*;
#(
  parameter int REFRESH_CYCLES = 780
) (
  input  logic clock,
  input  logic reset,
  input  logic i_refresh_taken,
  output logic o_refresh_pending,
  output logic o_refresh_overrun
);
  localparam int CW = refresh_cnt_w(REFRESH_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_CYCLES - 1);
  logic [CW-1:0] r_cnt;
  logic          r_pending, r_overrun;
  logic          w_expire;
  assign w_expire = r_cnt == '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= RELOAD;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_cnt     <= w_expire ? RELOAD : r_cnt - CW'(1);
      r_pending <= w_expire | (r_pending & ~i_refresh_taken);
      r_overrun <= r_overrun | (w_expire & r_pending);
    end
  end
  assign o_refresh_pending = r_pending;
  assign o_refresh_overrun = r_overrun;
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin two-port sequencer for one SDRAM controller with refresh injection.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 25,
  parameter int DATA_WIDTH     = 16,
  parameter int REFRESH_CYCLES = 780
) (
  input logic           clock,
  input logic           reset,
  sdram_arbiter_if.slave bus
);
  state_t                r_state;
  logic                  r_rr, r_port, r_served0, r_served1;
  logic                  r_ack0, r_ack1, r_start, r_refresh, r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic                  w_elig0, w_elig1, w_win, w_pending, w_overrun, w_taken;
  assign w_elig0 = bus.req0 & ~r_served0;
  assign w_elig1 = bus.req1 & ~r_served1;
  assign w_win   = (w_elig0 & w_elig1) ? r_rr : w_elig1;
  assign w_taken = r_state == S_REF_ISSUE;
  sdram_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_timer (
    .clock             (clock),
    .reset             (reset),
    .i_refresh_taken   (w_taken),
    .o_refresh_pending (w_pending),
    .o_refresh_overrun (w_overrun)
  );
  // served flags block a still-held request from being granted twice
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rr      <= PORT_INSTR;
      r_port    <= PORT_INSTR;
      r_served0 <= 1'b0;
      r_served1 <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_start   <= 1'b0;
      r_refresh <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      r_served0 <= bus.req0 & (r_served0 | r_ack0);
      r_served1 <= bus.req1 & (r_served1 | r_ack1);
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_start   <= 1'b0;
      r_refresh <= 1'b0;
      case (r_state)
        S_IDLE:
          if (w_pending) begin
            r_refresh <= 1'b1;
            r_state   <= S_REF_ISSUE;
          end else if (w_elig0 | w_elig1) begin
            r_we    <= w_win ? bus.we1 : bus.we0;
            r_addr  <= w_win ? bus.addr1 : bus.addr0;
            r_wdata <= w_win ? bus.wdata1 : bus.wdata0;
            r_port  <= w_win;
            r_rr    <= ~w_win;
            r_start <= 1'b1;
            r_state <= S_ISSUE;
          end
        S_ISSUE, S_WAIT:
          if (bus.mem_done) begin
            if (!r_we) r_rdata <= bus.mem_rdata;
            r_ack0  <= r_port == PORT_INSTR;
            r_ack1  <= r_port == PORT_DATA;
            r_state <= S_RESPOND;
          end else begin
            r_state <= S_WAIT;
          end
        S_REF_ISSUE: r_state <= bus.mem_done ? S_IDLE : S_REF_WAIT;
        S_REF_WAIT:  r_state <= bus.mem_done ? S_IDLE : S_REF_WAIT;
        S_RESPOND:   r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.ack0            = r_ack0;
  assign bus.ack1            = r_ack1;
  assign bus.rdata           = r_rdata;
  assign bus.mem_start       = r_start;
  assign bus.mem_refresh     = r_refresh;
  assign bus.mem_we          = r_we;
  assign bus.mem_addr        = r_addr;
  assign bus.mem_wdata       = r_wdata;
  assign bus.refresh_overrun = w_overrun;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed and randomized checks of the arbiter against a transaction-level model.
module tb_sdram_arbiter;
  localparam int AW = 25;
  localparam int DW = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  sdram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REFRESH_CYCLES(16)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0, cyc = 0;
  int n_start = 0, n_ack0 = 0, n_ack1 = 0, n_ref = 0, cyc_start = 0, cyc_ref = 0;
  int dcnt = 0, lat = 1;
  int q_grant[$];
  bit armed = 0, acc = 0, done_prev = 0, rnd = 0, auto_drop = 1, rearm = 0, d0 = 0, d1 = 0;
  bit cmd_we = 0, lastg = 1;
  bit pend[2], pend_s[2], req_we[2];
  logic [AW-1:0] req_addr[2];
  logic [DW-1:0] req_wd[2];
  logic [DW-1:0] rd_next = '0, rd_exp = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    int p;
    @(posedge clock);
    #1;
    cyc++;
    if (rnd) begin
      chk("ack0_timing", bus.ack0, done_prev && acc && !lastg);
      chk("ack1_timing", bus.ack1, done_prev && acc && lastg);
      chk("no_overrun", bus.refresh_overrun, 0);
      if (bus.ack0 || bus.ack1) chk("rnd_rdata", bus.rdata, rd_exp);
      if (bus.mem_start) begin
        p = int'(bus.mem_addr[AW-1]);
        chk("eligible", pend_s[p], 1);
        if (pend_s[0] && pend_s[1]) chk("round_robin", p, !lastg);
        chk("fields", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {req_we[p], req_addr[p], req_wd[p]});
      end
    end
    if (bus.ack0) n_ack0++;
    if (bus.ack1) n_ack1++;
    if (bus.mem_refresh) begin n_ref++; cyc_ref = cyc; end
    if (bus.mem_start || bus.mem_refresh) begin
      if (rnd) chk("overlap", armed, 0);
      armed = 1;
      acc   = bus.mem_start;
      dcnt  = rnd ? int'($urandom_range(0, 3)) : lat;
      if (rnd) rd_next = DW'($urandom);
      if (bus.mem_start) begin
        n_start++;
        cyc_start = cyc;
        lastg  = bus.mem_addr[AW-1];
        cmd_we = bus.mem_we;
        q_grant.push_back(int'(lastg));
      end
    end else if (armed) dcnt--;
    done_prev    = 0;
    bus.mem_done = 1'b0;
    if (armed && dcnt == 0) begin
      bus.mem_done  = 1'b1;
      bus.mem_rdata = rd_next;
      if (acc && !cmd_we) rd_exp = rd_next;
      armed     = 0;
      done_prev = 1;
    end
    if (rnd) begin
      for (int k = 0; k < 2; k++) begin
        if (k == 0 ? bus.ack0 : bus.ack1) pend[k] = 0;
        else if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k]     = 1;
          req_we[k]   = 1'($urandom);
          req_addr[k] = {1'(k), 24'($urandom)};
          req_wd[k]   = DW'($urandom);
        end
      end
      bus.req0 = pend[0]; bus.we0 = req_we[0]; bus.addr0 = req_addr[0]; bus.wdata0 = req_wd[0];
      bus.req1 = pend[1]; bus.we1 = req_we[1]; bus.addr1 = req_addr[1]; bus.wdata1 = req_wd[1];
    end else begin
      if (d0) begin if (rearm) bus.req0 = 1'b1; d0 = 0; end
      if (d1) begin if (rearm) bus.req1 = 1'b1; d1 = 0; end
      if (bus.ack0 && auto_drop) begin bus.req0 = 1'b0; d0 = 1; end
      if (bus.ack1 && auto_drop) begin bus.req1 = 1'b0; d1 = 1; end
    end
    pend_s = pend;
  endtask

  task automatic do_reset();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    reset = 1'b1;
    armed = 0; d0 = 0; d1 = 0; lastg = 1; rd_exp = '0;
    pend = '{0, 0}; pend_s = '{0, 0};
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ack(input string tag, input int port, input int base, input int lim);
    int i = 0;
    while ((port == 0 ? n_ack0 : n_ack1) <= base && i < lim) begin tick(); i++; end
    chk(tag, (port == 0 ? n_ack0 : n_ack1) > base, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_flags"}, {bus.ack0, bus.ack1, bus.mem_start, bus.mem_refresh, bus.refresh_overrun, bus.mem_we}, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
  endtask

  initial begin
    int s, a, r;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.mem_done = 0; bus.mem_rdata = '0;
    do_reset();
    chk_reset_outputs("reset");

    // single read, controller answers two cycles after mem_start
    lat = 2; rd_next = 16'hBEEF; auto_drop = 1;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 25'h0000123;
    tick();
    chk("t1_start", bus.mem_start, 1);
    chk("t1_addr", bus.mem_addr, 25'h0000123);
    chk("t1_we", bus.mem_we, 0);
    tick();
    chk("t1_start_pulse", bus.mem_start, 0);
    tick();
    chk("t1_ack_early", bus.ack0, 0);
    tick();
    chk("t1_ack", bus.ack0, 1);
    chk("t1_rdata", bus.rdata, 16'hBEEF);
    tick();
    chk("t1_ack_pulse", bus.ack0, 0);
    chk("t1_counts", {n_start, n_ack1}, {32'd1, 32'd0});

    // simultaneous requests, then repeated re-requests alternate
    do_reset();
    q_grant.delete();
    lat = 1; rearm = 1;
    bus.addr0 = 25'h00000A0; bus.addr1 = 25'h10000B0; bus.we0 = 0; bus.we1 = 1;
    bus.req0 = 1; bus.req1 = 1;
    for (int i = 0; i < 200 && q_grant.size() < 4; i++) tick();
    chk("t2_grants", q_grant.size() >= 4, 1);
    if (q_grant.size() >= 4) chk("t2_order", {q_grant[0], q_grant[1], q_grant[2], q_grant[3]}, {32'd0, 32'd1, 32'd0, 32'd1});
    rearm = 0;
    repeat (30) tick();

    // held request is served exactly once until it drops
    do_reset();
    auto_drop = 0; lat = 1;
    s = n_start; a = n_ack1;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 25'h1000777;
    wait_ack("t3_ack_wait", 1, a, 30);
    repeat (20) tick();
    chk("t3_once", {n_start - s, n_ack1 - a}, {32'd1, 32'd1});
    bus.req1 = 0;
    tick();
    bus.req1 = 1;
    wait_ack("t3_ack_wait2", 1, a + 1, 30);
    repeat (10) tick();
    chk("t3_twice", {n_start - s, n_ack1 - a}, {32'd2, 32'd2});
    bus.req1 = 0;
    auto_drop = 1;
    tick();

    // refresh wins over a waiting request
    do_reset();
    lat = 1; r = n_ref; a = n_ack0;
    repeat (16) tick();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 25'h0000456; rd_next = 16'h1357;
    tick();
    chk("t4_refresh", {bus.mem_refresh, bus.mem_start}, 2'b10);
    wait_ack("t4_ack_wait", 0, a, 30);
    chk("t4_ref_first", {n_ref - r, 31'd0, cyc_start > cyc_ref}, {32'd1, 32'd1});
    chk("t4_rdata", bus.rdata, 16'h1357);
    chk("t4_overrun", bus.refresh_overrun, 0);
    tick();

    // stalled write overruns the refresh interval
    do_reset();
    lat = 40; r = n_ref; a = n_ack0; rd_next = 16'h1234;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 25'h0000999; bus.wdata0 = 16'h5A5A;
    wait_ack("t5_ack_wait", 0, a, 60);
    chk("t5_overrun", bus.refresh_overrun, 1);
    chk("t5_rdata_kept", bus.rdata, 0);
    chk("t5_wdata_held", bus.mem_wdata, 16'h5A5A);
    chk("t5_no_ref_yet", n_ref - r, 0);
    lat = 1;
    repeat (4) tick();
    chk("t5_one_ref", n_ref - r, 1);
    repeat (20) tick();
    chk("t5_sticky", bus.refresh_overrun, 1);

    // reset during WAIT abandons the access
    do_reset();
    lat = 1; rd_next = 16'h7777; a = n_ack0;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 25'h0000321;
    wait_ack("t6_pre_ack", 0, a, 20);
    tick();
    lat = 40;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 25'h0ABCDEF; bus.wdata0 = 16'hCAFE;
    repeat (3) tick();
    chk("t6_in_wait", {bus.mem_addr, bus.mem_wdata, bus.rdata}, {25'h0ABCDEF, 16'hCAFE, 16'h7777});
    reset = 1; armed = 0;
    tick();
    chk_reset_outputs("t6_reset");
    reset = 0; bus.req0 = 0;
    a = n_ack0;
    repeat (6) tick();
    chk("t6_no_ack", n_ack0 - a, 0);
    lat = 2; rd_next = 16'h4321;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 25'h0000042;
    wait_ack("t6_new_ack", 0, a, 30);
    chk("t6_rdata", bus.rdata, 16'h4321);
    tick();

    // randomized traffic against the transaction model
    do_reset();
    r = n_ref;
    rnd = 1;
    repeat (600) tick();
    rnd = 0;
    chk("rnd_ref_count", (n_ref - r) >= 35 && (n_ref - r) <= 37, 1);
    bus.req0 = 0; bus.req1 = 0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
